cpu_io_responder: RTL and testbench

- Memory-mapped I/O responder on the CPU's I/O bus. The CPU is the initiator; this block is the peripheral end.
- Completes CPU load/store requests to four output ports, four input ports, a status register and an interrupt-enable register, using a four-phase req/ack handshake.
- Instantiated beside the CPU core in the CPU top level. Input ports come from off-chip or asynchronous sources and are synchronised here.

---
 rtl/cpu_io_responder.sv | 136 +++++++++++++
 tb/tb_cpu_io_responder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_io_responder.sv
// Memory-mapped I/O peripheral on the CPU I/O bus: four output ports, four synchronised
// input ports with change flags, a W1C status register and an interrupt-enable register.
module cpu_io_responder #(
    parameter int DW          = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          io_req,
    input  logic          io_we,
    input  logic [2:0]    io_addr,
    input  logic [DW-1:0] io_wdata,
    output logic [DW-1:0] io_rdata,
    output logic          io_ack,
    input  logic [DW-1:0] in_port0,
    input  logic [DW-1:0] in_port1,
    input  logic [DW-1:0] in_port2,
    input  logic [DW-1:0] in_port3,
    output logic [DW-1:0] out_port0,
    output logic [DW-1:0] out_port1,
    output logic [DW-1:0] out_port2,
    output logic [DW-1:0] out_port3,
    output logic          io_irq
);

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    localparam logic [2:0] ADDR_STATUS = 3'd4;
    localparam logic [2:0] ADDR_IRQEN  = 3'd5;

    state_t state, state_nxt;
    logic   access;

    logic [3:0]          cnt;
    logic                we_q;
    logic [2:0]          addr_q;
    logic [DW-1:0]       wdata_q;
    logic [3:0][DW-1:0]  sync1, sync2, prev, outs;
    logic [3:0]          new_flag, irq_en, changed, clr;
    logic [DW-1:0]       rdata_nxt;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        access    = 1'b0;
        case (state)
            IDLE: if (io_req) state_nxt = BUSY;
            BUSY: if (cnt == 4'd0) begin
                access    = 1'b1;
                state_nxt = ACK;
            end
            ACK:  if (!io_req) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bus fields are captured once so that bus activity during BUSY is ignored
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state == IDLE && io_req) begin
            cnt     <= 4'(WAIT_CYCLES);
            we_q    <= io_we;
            addr_q  <= io_addr;
            wdata_q <= io_wdata;
        end else if (state == BUSY && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    always_comb begin
        changed = '0;
        for (int i = 0; i < 4; i++) changed[i] = (sync2[i] != prev[i]);
    end

    // Read-of-port and STATUS W1C clears; a simultaneous new change wins over both
    always_comb begin
        clr = '0;
        if (access && !we_q && !addr_q[2]) clr[addr_q[1:0]] = 1'b1;
        if (access && we_q && addr_q == ADDR_STATUS) clr = clr | wdata_q[3:0];
    end

    always_comb begin
        case (addr_q)
            3'd0, 3'd1, 3'd2, 3'd3: rdata_nxt = sync2[addr_q[1:0]];
            ADDR_STATUS:            rdata_nxt = {{(DW-4){1'b0}}, new_flag};
            ADDR_IRQEN:             rdata_nxt = {{(DW-4){1'b0}}, irq_en};
            default:                rdata_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            prev     <= '0;
            new_flag <= '0;
        end else begin
            sync1    <= {in_port3, in_port2, in_port1, in_port0};
            sync2    <= sync1;
            prev     <= sync2;
            new_flag <= changed | (new_flag & ~clr);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outs     <= '0;
            irq_en   <= '0;
            io_rdata <= '0;
        end else if (access) begin
            if (we_q) begin
                if (!addr_q[2])               outs[addr_q[1:0]] <= wdata_q;
                else if (addr_q == ADDR_IRQEN) irq_en           <= wdata_q[3:0];
            end else begin
                io_rdata <= rdata_nxt;
            end
        end
    end

    assign io_ack    = (state == ACK);
    assign io_irq    = |(new_flag & irq_en);
    assign out_port0 = outs[0];
    assign out_port1 = outs[1];
    assign out_port2 = outs[2];
    assign out_port3 = outs[3];

endmodule

// File: tb/tb_cpu_io_responder.sv
// Scoreboard bench for cpu_io_responder: one instance with WAIT_CYCLES=1 for the register
// map and flag behaviour, a second with WAIT_CYCLES=3 for protocol-violation and reset cases.
module tb_cpu_io_responder;

    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, io_req, io_we, io_ack, io_irq;
    logic [2:0]    io_addr;
    logic [DW-1:0] io_wdata, io_rdata;
    logic [DW-1:0] in_port0, in_port1, in_port2, in_port3;
    logic [DW-1:0] out_port0, out_port1, out_port2, out_port3;

    logic          b_reset, b_req, b_we, b_ack, b_irq;
    logic [2:0]    b_addr;
    logic [DW-1:0] b_wdata, b_rdata;
    logic [DW-1:0] b_out0, b_out1, b_out2, b_out3;
    logic [DW-1:0] b_in;

    int checks   = 0;
    int failures = 0;
    logic [DW-1:0] exp_q[$];

    cpu_io_responder #(.DW(DW), .WAIT_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .io_req(io_req), .io_we(io_we), .io_addr(io_addr),
        .io_wdata(io_wdata), .io_rdata(io_rdata), .io_ack(io_ack),
        .in_port0(in_port0), .in_port1(in_port1), .in_port2(in_port2), .in_port3(in_port3),
        .out_port0(out_port0), .out_port1(out_port1), .out_port2(out_port2), .out_port3(out_port3),
        .io_irq(io_irq)
    );

    cpu_io_responder #(.DW(DW), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .reset(b_reset), .io_req(b_req), .io_we(b_we), .io_addr(b_addr),
        .io_wdata(b_wdata), .io_rdata(b_rdata), .io_ack(b_ack),
        .in_port0(b_in), .in_port1(b_in), .in_port2(b_in), .in_port3(b_in),
        .out_port0(b_out0), .out_port1(b_out1), .out_port2(b_out2), .out_port3(b_out3),
        .io_irq(b_irq)
    );

    // One full transaction on the WAIT_CYCLES=1 instance; starts and ends at a falling edge
    task automatic bus_xfer(input logic we, input logic [2:0] addr, input logic [DW-1:0] wdata,
                            input logic [DW-1:0] exp_rdata, input string name);
        int n;
        logic [DW-1:0] e;
        io_req = 1'b1; io_we = we; io_addr = addr; io_wdata = wdata;
        if (!we) exp_q.push_back(exp_rdata);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!io_ack && n < 20);
        checks++;
        if (io_ack !== 1'b1 || n != 3) begin
            failures++;
            $display("FAIL %s ack_latency got ack=%b after %0d cycles, want ack=1 after 3", name, io_ack, n);
        end
        e = '0;
        if (!we) begin
            e = exp_q.pop_front();
            checks++;
            if (io_rdata !== e) begin
                failures++;
                $display("FAIL %s rdata got=%h want=%h", name, io_rdata, e);
            end
        end
        io_req = 1'b0;
        @(negedge clk);
        checks++;
        if (io_ack !== 1'b0 || (!we && io_rdata !== e)) begin
            failures++;
            $display("FAIL %s ack_fall/rdata_hold got ack=%b rdata=%h want ack=0 rdata=%h", name, io_ack, io_rdata, e);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        checks++;
        if ({io_ack, io_irq, io_rdata, out_port0, out_port1, out_port2, out_port3} !== '0) begin
            failures++;
            $display("FAIL reset_state got ack=%b irq=%b rdata=%h outs=%h%h%h%h want all 0",
                     io_ack, io_irq, io_rdata, out_port0, out_port1, out_port2, out_port3);
        end
        bus_xfer(1'b1, 3'd0, 8'hFF, 8'h00, "pre_reset_wr");
        bus_xfer(1'b1, 3'd5, 8'h01, 8'h00, "pre_reset_irqen");
        bus_xfer(1'b0, 3'd6, 8'h00, 8'h00, "pre_reset_rd");
        in_port0 = 8'h11;
        repeat (4) @(negedge clk);
        checks++;
        if (io_irq !== 1'b1 || out_port0 !== 8'hFF) begin
            failures++;
            $display("FAIL pre_reset_setup got irq=%b out0=%h want irq=1 out0=ff", io_irq, out_port0);
        end
        #2 reset = 1'b1;
        in_port0 = 8'h00;
        #1;
        checks++;
        if (out_port0 !== 8'h00 || io_irq !== 1'b0 || io_ack !== 1'b0 || io_rdata !== 8'h00) begin
            failures++;
            $display("FAIL async_reset got out0=%h irq=%b ack=%b rdata=%h want 00 0 0 00",
                     out_port0, io_irq, io_ack, io_rdata);
        end
        #9 reset = 1'b0;
        @(negedge clk);
        bus_xfer(1'b0, 3'd5, 8'h00, 8'h00, "irqen_after_reset");
    endtask

    task automatic test_write();
        bus_xfer(1'b1, 3'd2, 8'hA5, 8'h00, "wr_port2");
        checks++;
        if (out_port2 !== 8'hA5 || out_port0 !== 8'h00 || out_port1 !== 8'h00 || out_port3 !== 8'h00) begin
            failures++;
            $display("FAIL wr_port2_outs got %h %h %h %h want 00 00 a5 00",
                     out_port0, out_port1, out_port2, out_port3);
        end
    endtask

    task automatic test_read_flag();
        in_port1 = 8'h3C;
        repeat (4) @(negedge clk);
        bus_xfer(1'b0, 3'd4, 8'h00, 8'h02, "status_flag1");
        bus_xfer(1'b0, 3'd1, 8'h00, 8'h3C, "rd_port1");
        bus_xfer(1'b0, 3'd4, 8'h00, 8'h00, "status_cleared");
    endtask

    task automatic test_irq();
        bus_xfer(1'b1, 3'd5, 8'h01, 8'h00, "wr_irqen");
        bus_xfer(1'b0, 3'd5, 8'h00, 8'h01, "rd_irqen");
        in_port0 = 8'h55;
        repeat (4) @(negedge clk);
        checks++;
        if (io_irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_raise got=%b want=1", io_irq);
        end
        bus_xfer(1'b1, 3'd4, 8'h01, 8'h00, "w1c_flag0");
        checks++;
        if (io_irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_w1c got=%b want=0", io_irq);
        end
        in_port3 = 8'h77;
        repeat (4) @(negedge clk);
        checks++;
        if (io_irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_masked got=%b want=0", io_irq);
        end
        bus_xfer(1'b0, 3'd4, 8'h00, 8'h08, "status_flag3");
        bus_xfer(1'b1, 3'd4, 8'h08, 8'h00, "w1c_flag3");
        bus_xfer(1'b0, 3'd4, 8'h00, 8'h00, "status_after_w1c");
    endtask

    task automatic test_collision();
        // The change reaches sync2 just as the port-2 read clears the flag
        in_port2 = 8'h99;
        bus_xfer(1'b0, 3'd2, 8'h00, 8'h99, "rd_port2_collide");
        bus_xfer(1'b0, 3'd4, 8'h00, 8'h04, "status_collide");
        bus_xfer(1'b1, 3'd4, 8'h04, 8'h00, "w1c_flag2");
    endtask

    task automatic test_reserved();
        bus_xfer(1'b1, 3'd7, 8'hFF, 8'h00, "wr_addr7");
        bus_xfer(1'b0, 3'd7, 8'h00, 8'h00, "rd_addr7");
        bus_xfer(1'b0, 3'd6, 8'h00, 8'h00, "rd_addr6");
        checks++;
        if (out_port2 !== 8'hA5 || out_port0 !== 8'h00 || out_port1 !== 8'h00 || out_port3 !== 8'h00) begin
            failures++;
            $display("FAIL reserved_no_side_effect got %h %h %h %h want 00 00 a5 00",
                     out_port0, out_port1, out_port2, out_port3);
        end
    endtask

    task automatic test_req_drop();
        int pulses;
        @(negedge clk);
        b_req = 1'b1; b_we = 1'b1; b_addr = 3'd1; b_wdata = 8'h5A;
        @(negedge clk);
        b_req = 1'b0; b_addr = 3'd2; b_wdata = 8'h00;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (b_ack) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL drop_ack_pulse got=%0d cycles want=1", pulses);
        end
        checks++;
        if (b_out1 !== 8'h5A || b_out2 !== 8'h00) begin
            failures++;
            $display("FAIL drop_access got out1=%h out2=%h want 5a 00", b_out1, b_out2);
        end
    endtask

    task automatic test_reset_busy();
        int  n;
        logic early;
        @(negedge clk);
        b_req = 1'b1; b_we = 1'b1; b_addr = 3'd3; b_wdata = 8'hC3;
        repeat (2) @(negedge clk);
        #2 b_reset = 1'b1;
        #1;
        checks++;
        if (b_out3 !== 8'h00 || b_ack !== 1'b0) begin
            failures++;
            $display("FAIL busy_reset got out3=%h ack=%b want 00 0", b_out3, b_ack);
        end
        @(negedge clk);
        #2 b_reset = 1'b0;
        n = 0;
        early = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (!b_ack && b_out3 !== 8'h00) early = 1'b1;
        end while (!b_ack && n < 30);
        checks++;
        if (b_ack !== 1'b1 || n != 5 || early) begin
            failures++;
            $display("FAIL busy_reset_retry got ack=%b cycles=%0d early=%b want ack=1 cycles=5 early=0", b_ack, n, early);
        end
        checks++;
        if (b_out3 !== 8'hC3) begin
            failures++;
            $display("FAIL busy_reset_retry_data got=%h want=c3", b_out3);
        end
        b_req = 1'b0;
        @(negedge clk);
        checks++;
        if (b_ack !== 1'b0) begin
            failures++;
            $display("FAIL busy_reset_ack_fall got=%b want=0", b_ack);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; io_req = 1'b0; io_we = 1'b0; io_addr = '0; io_wdata = '0;
        in_port0 = '0; in_port1 = '0; in_port2 = '0; in_port3 = '0;
        b_reset = 1'b1; b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_in = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0; b_reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_write();
        test_read_flag();
        test_irq();
        test_collision();
        test_reserved();
        test_req_drop();
        test_reset_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
